// File: rtl/dm_pkg.sv
// Shared types for the multi-cycle data memory: access-type codes, FSM states and
// the access legality check.
package dm_pkg;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp,
    StFlt
  } dm_state_e;

  // Alignment and type check; range is computed by the caller since it depends on DEPTH.
  function automatic logic dm_legal(input logic [2:0] dmtype, input logic [1:0] lsb,
                                    input logic in_range);
    logic ok;
    case (dmtype)
      DM_WORD:            ok = (lsb == 2'b00);
      DM_HALF, DM_HALF_U: ok = ~lsb[0];
      DM_BYTE, DM_BYTE_U: ok = 1'b1;
      default:            ok = 1'b0;
    endcase
    return ok & in_range;
  endfunction

endpackage

// File: rtl/dm_lane.sv
// Byte-lane steering: merges store data into the old word and extends load data.
module dm_lane
  import dm_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  dmtype_i,
  input  logic [1:0]  lsb_i,
  output logic [31:0] wr_word_o,
  output logic [31:0] rd_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = old_word_i[{lsb_i, 3'b000} +: 8];
    half_sel  = lsb_i[1] ? old_word_i[31:16] : old_word_i[15:0];
    wr_word_o = old_word_i;
    rd_data_o = old_word_i;
    case (dmtype_i)
      DM_HALF, DM_HALF_U: begin
        if (lsb_i[1]) wr_word_o[31:16] = wdata_i[15:0];
        else          wr_word_o[15:0]  = wdata_i[15:0];
        rd_data_o = {{16{half_sel[15] & (dmtype_i == DM_HALF)}}, half_sel};
      end
      DM_BYTE, DM_BYTE_U: begin
        wr_word_o[{lsb_i, 3'b000} +: 8] = wdata_i[7:0];
        rd_data_o = {{24{byte_sel[7] & (dmtype_i == DM_BYTE)}}, byte_sel};
      end
      default: begin
        wr_word_o = wdata_i;
        rd_data_o = old_word_i;
      end
    endcase
  end

endmodule

// File: rtl/dm_wait_ctrl.sv
// Multi-cycle data memory with configurable latency, CPU stall and fault detection.
// Define DM_STATS_EN to add saturating load/store/fault counters.
module dm_wait_ctrl
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        dmtype,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              fault,
  output logic              stall
`ifdef DM_STATS_EN
  ,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt,
  output logic [15:0]       flt_cnt
`endif
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  dm_state_e       state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IdxW+1:0] addr_q;
  logic            we_q;
  logic [2:0]      dmtype_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic [31:0]     mem_q [DEPTH];

  logic            in_range, legal, latch_en, access;
  logic [31:0]     wr_word, rd_ext;

  assign in_range = ((addr >> (IdxW + 2)) == '0);
  assign legal    = dm_legal(dmtype, addr[1:0], in_range);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    access   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (legal) begin
            latch_en = 1'b1;
            cnt_d    = 4'(LATENCY - 1);
            state_d  = StWait;
          end else begin
            state_d = StFlt;
          end
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      StFlt:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      dmtype_q <= DM_WORD;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_en) begin
        addr_q   <= addr[IdxW+1:0];
        we_q     <= we;
        dmtype_q <= dmtype;
        wdata_q  <= wdata;
      end
      if (access && !we_q) rdata_q <= rd_ext;
    end
  end

  // RAM has no reset; the rstn gate keeps a store from landing on the aborting edge.
  always_ff @(posedge clk) begin
    if (rstn && access && we_q) mem_q[addr_q[IdxW+1:2]] <= wr_word;
  end

  dm_lane u_lane (
    .old_word_i (mem_q[addr_q[IdxW+1:2]]),
    .wdata_i    (wdata_q),
    .dmtype_i   (dmtype_q),
    .lsb_i      (addr_q[1:0]),
    .wr_word_o  (wr_word),
    .rd_data_o  (rd_ext)
  );

  assign rdata = rdata_q;
  assign done  = (state_q == StResp);
  assign fault = (state_q == StFlt);
  assign stall = req & ~done & ~fault;

`ifdef DM_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q, flt_cnt_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_cnt_q  <= 16'd0;
      wr_cnt_q  <= 16'd0;
      flt_cnt_q <= 16'd0;
    end else begin
      if (access && !we_q && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (access && we_q && wr_cnt_q != 16'hFFFF)  wr_cnt_q <= wr_cnt_q + 16'd1;
      if (state_d == StFlt && state_q == StIdle && flt_cnt_q != 16'hFFFF) begin
        flt_cnt_q <= flt_cnt_q + 16'd1;
      end
    end
  end

  assign rd_cnt  = rd_cnt_q;
  assign wr_cnt  = wr_cnt_q;
  assign flt_cnt = flt_cnt_q;
`endif

endmodule

// File: tb/tb_dm_wait_ctrl.sv
// Directed self-checking bench for dm_wait_ctrl (DEPTH=128, LATENCY=2).
module tb_dm_wait_ctrl;

  logic        clk;
  logic        rstn;
  logic        req;
  logic        we;
  logic [2:0]  dmtype;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        fault;
  logic        stall;
`ifdef DM_STATS_EN
  logic [15:0] rd_cnt, wr_cnt, flt_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  dm_wait_ctrl #(
    .DEPTH   (128),
    .LATENCY (2),
    .ADDR_W  (32)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .req     (req),
    .we      (we),
    .dmtype  (dmtype),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .done    (done),
    .fault   (fault),
    .stall   (stall)
`ifdef DM_STATS_EN
    ,
    .rd_cnt  (rd_cnt),
    .wr_cnt  (wr_cnt),
    .flt_cnt (flt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One request held until done/fault; cyc is the cycle of the response (cycle 0 = req seen).
  task automatic access(input logic w, input logic [2:0] t, input logic [31:0] a,
                        input logic [31:0] d, output int cyc, output logic flt,
                        output logic [31:0] rd, output logic [7:0] sh);
    @(posedge clk); #1;
    req = 1'b1; we = w; dmtype = t; addr = a; wdata = d;
    cyc = -1; flt = 1'b0; rd = 32'd0; sh = 8'd0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      sh = {sh[6:0], stall};
      if (done || fault) begin
        cyc = c; flt = fault; rd = rdata;
        break;
      end
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  int          cyc;
  logic        flt;
  logic [31:0] rd;
  logic [7:0]  sh;
  logic        seen_done;

  initial begin
    rstn = 1'b0; req = 1'b0; we = 1'b0; dmtype = 3'b000; addr = 32'd0; wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rst_rdata", rdata, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);

    access(1'b1, 3'b000, 32'h10, 32'hDEADBEEF, cyc, flt, rd, sh);
    check("sw_cycle", 32'(cyc), 32'd3);
    check("sw_stall", {24'd0, sh}, 32'h0E);
    check("sw_rdata_kept", rd, 32'd0);

    access(1'b0, 3'b000, 32'h10, 32'd0, cyc, flt, rd, sh);
    check("lw_cycle", 32'(cyc), 32'd3);
    check("lw_data", rd, 32'hDEADBEEF);

    access(1'b1, 3'b011, 32'h11, 32'hFFFFFF5A, cyc, flt, rd, sh);
    check("sb_cycle", 32'(cyc), 32'd3);
    access(1'b0, 3'b000, 32'h10, 32'd0, cyc, flt, rd, sh);
    check("lw_merged", rd, 32'hDEAD5AEF);
    access(1'b0, 3'b011, 32'h13, 32'd0, cyc, flt, rd, sh);
    check("lb_13", rd, 32'hFFFFFFDE);
    access(1'b0, 3'b100, 32'h13, 32'd0, cyc, flt, rd, sh);
    check("lbu_13", rd, 32'h000000DE);
    access(1'b0, 3'b001, 32'h12, 32'd0, cyc, flt, rd, sh);
    check("lh_12", rd, 32'hFFFFDEAD);
    access(1'b0, 3'b010, 32'h12, 32'd0, cyc, flt, rd, sh);
    check("lhu_12", rd, 32'h0000DEAD);
    access(1'b0, 3'b011, 32'h11, 32'd0, cyc, flt, rd, sh);
    check("lb_11", rd, 32'h0000005A);

    // Misaligned word load
    access(1'b0, 3'b000, 32'h12, 32'd0, cyc, flt, rd, sh);
    check("lw_mis_flt", {31'd0, flt}, 32'd1);
    check("lw_mis_cycle", 32'(cyc), 32'd1);
    @(negedge clk);
    check("flt_one_pulse", {31'd0, fault}, 32'd0);
    access(1'b0, 3'b000, 32'h10, 32'd0, cyc, flt, rd, sh);
    check("mem_after_flt", rd, 32'hDEAD5AEF);

    // Out-of-range store must not alias onto word 0
    access(1'b1, 3'b000, 32'h0, 32'h11111111, cyc, flt, rd, sh);
    access(1'b1, 3'b000, 32'h200, 32'h00000BAD, cyc, flt, rd, sh);
    check("sw_oor_flt", {31'd0, flt}, 32'd1);
    check("sw_oor_cycle", 32'(cyc), 32'd1);
    access(1'b0, 3'b000, 32'h0, 32'd0, cyc, flt, rd, sh);
    check("oor_no_write", rd, 32'h11111111);
    access(1'b0, 3'b111, 32'h10, 32'd0, cyc, flt, rd, sh);
    check("type7_flt", {31'd0, flt}, 32'd1);
    access(1'b1, 3'b001, 32'h11, 32'd0, cyc, flt, rd, sh);
    check("sh_mis_flt", {31'd0, flt}, 32'd1);

    // Upper-half store keeps lower half
    access(1'b1, 3'b000, 32'h14, 32'hAABBCCDD, cyc, flt, rd, sh);
    access(1'b1, 3'b001, 32'h16, 32'h00001234, cyc, flt, rd, sh);
    access(1'b0, 3'b000, 32'h14, 32'd0, cyc, flt, rd, sh);
    check("sh_upper", rd, 32'h1234CCDD);

    // req drops and inputs change during WAIT: latched load still completes
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; dmtype = 3'b000; addr = 32'h10;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b1; addr = 32'h14; wdata = 32'd0; dmtype = 3'b011;
    cyc = -1;
    for (int c = 1; c < 12; c++) begin
      @(negedge clk);
      if (done) begin
        cyc = c; rd = rdata;
        break;
      end
    end
    check("drop_cycle", 32'(cyc), 32'd3);
    check("drop_data", rd, 32'hDEAD5AEF);
    access(1'b0, 3'b000, 32'h14, 32'd0, cyc, flt, rd, sh);
    check("drop_no_store", rd, 32'h1234CCDD);

    // Reset during a store's WAIT aborts it
    access(1'b1, 3'b000, 32'h20, 32'hCAFEF00D, cyc, flt, rd, sh);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; dmtype = 3'b000; addr = 32'h20; wdata = 32'h12345678;
    @(posedge clk); #1;
    rstn = 1'b0; req = 1'b0;
    seen_done = 1'b0;
    @(negedge clk);
    seen_done |= done;
    @(posedge clk); #1 rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      seen_done |= done;
    end
    check("rst_mid_no_done", {31'd0, seen_done}, 32'd0);
    check("rst_mid_rdata", rdata, 32'd0);
`ifdef DM_STATS_EN
    check("stat_rd0", {16'd0, rd_cnt}, 32'd0);
`endif
    access(1'b0, 3'b000, 32'h20, 32'd0, cyc, flt, rd, sh);
    check("rst_mid_mem", rd, 32'hCAFEF00D);

    // 3 loads, 2 stores, 1 fault since reset
    access(1'b0, 3'b000, 32'h10, 32'd0, cyc, flt, rd, sh);
    access(1'b0, 3'b000, 32'h14, 32'd0, cyc, flt, rd, sh);
    access(1'b1, 3'b000, 32'h30, 32'h01020304, cyc, flt, rd, sh);
    access(1'b1, 3'b100, 32'h31, 32'h000000AB, cyc, flt, rd, sh);
    access(1'b0, 3'b000, 32'h31, 32'd0, cyc, flt, rd, sh);
    check("last_flt", {31'd0, flt}, 32'd1);
`ifdef DM_STATS_EN
    check("stat_rd", {16'd0, rd_cnt}, 32'd3);
    check("stat_wr", {16'd0, wr_cnt}, 32'd2);
    check("stat_flt", {16'd0, flt_cnt}, 32'd1);
`endif
    access(1'b0, 3'b000, 32'h30, 32'd0, cyc, flt, rd, sh);
    check("sbu_merge", rd, 32'h0102AB04);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
